block_pixel_streamer: RTL and testbench

//  Reader/drain side of the supersample+channel buffer path. Accepts one

---
 rtl/jpeg_stream_pkg.sv | 28 ++
 rtl/block_hold_bank.sv | 42 ++++
 rtl/block_pixel_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_block_pixel_streamer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_stream_pkg.sv
// jpeg_stream_pkg: shared types for the block -> pixel drain path.
// Sample width comes from the `Q macro (normally supplied by sys_defs.svh);
// an 8-bit fallback keeps standalone builds of this slice complete.
`ifndef Q
`define Q 8
`endif

package jpeg_stream_pkg;

    localparam int QW   = `Q;
    localparam int NPIX = 64;

    // One output pixel, all three channels side by side.
    typedef struct packed {
        logic [QW-1:0] y;
        logic [QW-1:0] cb;
        logic [QW-1:0] cr;
    } pix_t;

    // One 8x8 block, indexed [row][col].
    typedef logic [7:0][7:0][QW-1:0] blk_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/block_hold_bank.sv
// block_hold_bank: holds one Y/Cb/Cr block triple and presents the pixel
// selected by a raster index. The read mux is combinational; the top
// registers whatever it picks.
module block_hold_bank
    import jpeg_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  blk_t       y_in,
    input  blk_t       cb_in,
    input  blk_t       cr_in,
    input  logic [5:0] rd_idx,
    output pix_t       rd_pix
);

    blk_t y_q;
    blk_t cb_q;
    blk_t cr_q;

    // Capture the whole triple in one cycle when loaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q  <= '0;
            cb_q <= '0;
            cr_q <= '0;
        end else if (load) begin
            y_q  <= y_in;
            cb_q <= cb_in;
            cr_q <= cr_in;
        end
    end

    // Raster index: upper three bits pick the row, lower three the column.
    always_comb begin
        rd_pix    = '0;
        rd_pix.y  = y_q[rd_idx[5:3]][rd_idx[2:0]];
        rd_pix.cb = cb_q[rd_idx[5:3]][rd_idx[2:0]];
        rd_pix.cr = cr_q[rd_idx[5:3]][rd_idx[2:0]];
    end

endmodule

// File: rtl/block_pixel_streamer.sv
// block_pixel_streamer: captures an aligned Y/Cb/Cr 8x8 triple in one cycle
// and drains it as 64 raster-order pixels under valid/ready.
// Optional: define STREAM_DBUF_EN for an active/shadow bank pair, which lets
// the next block be captured mid-stream and follow with no bubble.
module block_pixel_streamer
    import jpeg_stream_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    output logic          in_ready,
    input  blk_t          y_in,
    input  blk_t          cb_in,
    input  blk_t          cr_in,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [QW-1:0] pix_y,
    output logic [QW-1:0] pix_cb,
    output logic [QW-1:0] pix_cr,
    output logic [2:0]    pix_row,
    output logic [2:0]    pix_col,
    output logic          pix_last,
    output logic          drop_err
);

    state_t     state;
    logic [5:0] pix_idx;
    pix_t       pix_out;
    logic       capture;
    logic       accept;
    logic       at_last;
    pix_t       in_pix0;

    assign capture = valid_in & in_ready;
    assign accept  = pix_valid & pix_ready;
    assign at_last = (pix_idx == 6'(NPIX - 1));
    // Pixel 0 straight from the inputs, so a block loaded this cycle can be
    // presented on the next one without waiting for the bank.
    assign in_pix0 = {y_in[0][0], cb_in[0][0], cr_in[0][0]};

    assign pix_y    = pix_out.y;
    assign pix_cb   = pix_out.cb;
    assign pix_cr   = pix_out.cr;
    assign pix_row  = pix_idx[5:3];
    assign pix_col  = pix_idx[2:0];
    assign pix_last = at_last;

    // Sticky overrun flag: upstream never retries, so a dropped triple is lost.
    always_ff @(posedge clk) begin
        if (!rst)
            drop_err <= 1'b0;
        else if (valid_in && !in_ready)
            drop_err <= 1'b1;
    end

`ifdef STREAM_DBUF_EN

    logic       act;
    logic       sh;
    logic [1:0] full;
    logic       tgt;
    logic [1:0] load;
    logic [5:0] rd_idx [2];
    pix_t       bank_pix [2];
    pix_t       next_pix0;

    assign sh  = ~act;
    // Fill the active bank when idle, otherwise the shadow.
    assign tgt = full[act] ? sh : act;
    // First pixel of the following block: parked in the shadow, or arriving now.
    assign next_pix0 = full[sh] ? bank_pix[sh] : in_pix0;

    // Active bank looks one pixel ahead; shadow always offers pixel 0.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            rd_idx[b] = (1'(b) == act) ? pix_idx + 6'd1 : 6'd0;
            load[b]   = capture && (tgt == 1'(b));
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        block_hold_bank u_bank (
            .clk    (clk),
            .rst    (rst),
            .load   (load[b]),
            .y_in   (y_in),
            .cb_in  (cb_in),
            .cr_in  (cr_in),
            .rd_idx (rd_idx[b]),
            .rd_pix (bank_pix[b])
        );
    end

    // Stream FSM with bank swap on the last accept when a block is waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pix_idx   <= '0;
            pix_valid <= 1'b0;
            pix_out   <= '0;
            in_ready  <= 1'b0;
            act       <= 1'b0;
            full      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (capture) begin
                        state     <= STREAM;
                        pix_valid <= 1'b1;
                        pix_idx   <= '0;
                        pix_out   <= in_pix0;
                        full[act] <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept && at_last) begin
                        pix_idx   <= '0;
                        full[act] <= 1'b0;
                        in_ready  <= 1'b1;
                        if (full[sh] || capture) begin
                            act      <= sh;
                            full[sh] <= 1'b1;
                            pix_out  <= next_pix0;
                        end else begin
                            state     <= IDLE;
                            pix_valid <= 1'b0;
                            pix_out   <= '0;
                        end
                    end else begin
                        if (accept) begin
                            pix_idx <= pix_idx + 6'd1;
                            pix_out <= bank_pix[act];
                        end
                        if (capture)
                            full[sh] <= 1'b1;
                        in_ready <= ~(full[sh] | capture);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    pix_t       bank_pix;
    logic [5:0] rd_idx;

    // Look one pixel ahead so the output register loads the next beat.
    assign rd_idx = pix_idx + 6'd1;

    block_hold_bank u_bank (
        .clk    (clk),
        .rst    (rst),
        .load   (capture),
        .y_in   (y_in),
        .cb_in  (cb_in),
        .cr_in  (cr_in),
        .rd_idx (rd_idx),
        .rd_pix (bank_pix)
    );

    // Stream FSM: one block at a time, capture only while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pix_idx   <= '0;
            pix_valid <= 1'b0;
            pix_out   <= '0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (capture) begin
                        state     <= STREAM;
                        pix_valid <= 1'b1;
                        pix_idx   <= '0;
                        pix_out   <= in_pix0;
                        in_ready  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (at_last) begin
                            state     <= IDLE;
                            pix_valid <= 1'b0;
                            pix_idx   <= '0;
                            pix_out   <= '0;
                            in_ready  <= 1'b1;
                        end else begin
                            pix_idx <= pix_idx + 6'd1;
                            pix_out <= bank_pix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_block_pixel_streamer.sv
// tb_block_pixel_streamer: directed scoreboard bench for block_pixel_streamer.
module tb_block_pixel_streamer;
    import jpeg_stream_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          pix_ready = 1'b0;
    blk_t          y_in = '0;
    blk_t          cb_in = '0;
    blk_t          cr_in = '0;
    logic          in_ready;
    logic          pix_valid;
    logic [QW-1:0] pix_y;
    logic [QW-1:0] pix_cb;
    logic [QW-1:0] pix_cr;
    logic [2:0]    pix_row;
    logic [2:0]    pix_col;
    logic          pix_last;
    logic          drop_err;

    block_pixel_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .cb_in     (cb_in),
        .cr_in     (cr_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_y     (pix_y),
        .pix_cb    (pix_cb),
        .pix_cr    (pix_cr),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_last  (pix_last),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        pix_t       p;
        logic [5:0] idx;
    } exp_t;

    exp_t        sb[$];
    int          acc_cyc[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    int          cap_cyc = 0;
    logic        stalled = 1'b0;
    logic [63:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Block pattern: xm=0 gives y=8r+c, cb=0x80+r, cr=0x40+c.
    function automatic pix_t pat(input logic [7:0] xm, input int r, input int c);
        pix_t p;
        p.y  = QW'((8 * r + c) ^ int'(xm));
        p.cb = QW'((8'h80 + r) ^ int'(xm));
        p.cr = QW'((8'h40 + c) ^ int'(xm));
        return p;
    endfunction

    task automatic set_block(input logic [7:0] xm);
        pix_t p;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                p = pat(xm, r, c);
                y_in[r][c]  = p.y;
                cb_in[r][c] = p.cb;
                cr_in[r][c] = p.cr;
            end
    endtask

    task automatic push_block(input logic [7:0] xm);
        exp_t e;
        for (int k = 0; k < NPIX; k++) begin
            e.p   = pat(xm, k >> 3, k & 7);
            e.idx = 6'(k);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    // One cycle: drive, check held/accepted beat, optionally expect a capture.
    task automatic cyc(input logic rdy, input logic vin, input logic exp_cap, input logic [7:0] xm);
        logic [63:0] cur;
        exp_t        e;
        pix_ready = rdy;
        valid_in  = vin;
        cur = 64'({pix_valid, pix_y, pix_cb, pix_cr, pix_row, pix_col, pix_last});
        if (stalled)
            chk("stall_hold", cur, held);
        if (pix_valid && rdy) begin
            if (sb.size() == 0)
                chk("beat_expected", 64'(sb.size()), 64'd1);
            else begin
                e = sb.pop_front();
                chk("beat", 64'({pix_y, pix_cb, pix_cr, pix_row, pix_col, pix_last}),
                    64'({e.p, e.idx, (e.idx == 6'd63)}));
                acc_cyc.push_back(cyc_cnt);
            end
        end
        stalled = pix_valid && !rdy;
        held    = cur;
        if (exp_cap) begin
            chk("in_ready_at_capture", 64'(in_ready), 64'd1);
            cap_cyc = cyc_cnt;
            push_block(xm);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain(input int n, input logic rnd, input int budget);
        int b;
        b = budget;
        while (acc_cyc.size() < n && b > 0) begin
            cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0, 8'h00);
            b--;
        end
        chk("beat_count", 64'(acc_cyc.size()), 64'(n));
    endtask

    initial begin
        // 1: reset
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_drop_err", 64'(drop_err), 64'd0);
        chk("rst_pix", 64'({pix_y, pix_cb, pix_cr, pix_row, pix_col, pix_last}), 64'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 2: single block, ready held high
        acc_cyc.delete();
        set_block(8'h00);
        cyc(1'b1, 1'b1, 1'b1, 8'h00);
        chk("latency_valid", 64'(pix_valid), 64'd1);
        drain(64, 1'b0, 200);
        chk("first_beat_latency", 64'(acc_cyc[0] - cap_cyc), 64'd1);
        chk("back_to_back_span", 64'(acc_cyc[63] - acc_cyc[0]), 64'd63);
        chk("end_pix_valid", 64'(pix_valid), 64'd0);
        chk("end_in_ready", 64'(in_ready), 64'd1);

        // 3: random backpressure
        acc_cyc.delete();
        cyc(1'b1, 1'b1, 1'b1, 8'h00);
        drain(64, 1'b1, 2000);
        stalled = 1'b0;
        chk("bp_queue_empty", 64'(sb.size()), 64'd0);

`ifndef STREAM_DBUF_EN
        // 4: overrun pulse mid-stream is dropped
        acc_cyc.delete();
        cyc(1'b1, 1'b1, 1'b1, 8'h00);
        drain(5, 1'b0, 50);
        chk("overrun_in_ready", 64'(in_ready), 64'd0);
        set_block(8'hFF);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("drop_err_set", 64'(drop_err), 64'd1);
        drain(64, 1'b0, 200);
        tick();
        chk("drop_err_held", 64'(drop_err), 64'd1);
`endif

        // 5: two blocks; zero bubble with shadow bank, one-cycle gap without
        acc_cyc.delete();
        set_block(8'h00);
        cyc(1'b1, 1'b1, 1'b1, 8'h00);
`ifdef STREAM_DBUF_EN
        drain(10, 1'b0, 50);
        set_block(8'h5A);
        cyc(1'b1, 1'b1, 1'b1, 8'h5A);
        drain(128, 1'b0, 300);
        chk("dbuf_gap", 64'(acc_cyc[64] - acc_cyc[63]), 64'd1);
        chk("dbuf_span", 64'(acc_cyc[127] - acc_cyc[0]), 64'd127);
`else
        drain(64, 1'b0, 200);
        chk("gap_in_ready", 64'(in_ready), 64'd1);
        set_block(8'h5A);
        cyc(1'b1, 1'b1, 1'b1, 8'h5A);
        drain(128, 1'b0, 300);
        chk("sbuf_gap", 64'(acc_cyc[64] - acc_cyc[63]), 64'd2);
`endif

        // 6: reset mid-stream, then a fresh block from idx 0
        acc_cyc.delete();
        set_block(8'h33);
        cyc(1'b1, 1'b1, 1'b1, 8'h33);
        drain(30, 1'b0, 100);
        rst = 1'b0;
        tick();
        sb.delete();
        stalled = 1'b0;
        chk("midrst_pix_valid", 64'(pix_valid), 64'd0);
        chk("midrst_pix", 64'({pix_y, pix_cb, pix_cr, pix_row, pix_col, pix_last}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_drop_err", 64'(drop_err), 64'd0);
        rst = 1'b1;
        tick();
        chk("midrst_release_ready", 64'(in_ready), 64'd1);
        acc_cyc.delete();
        set_block(8'h11);
        cyc(1'b1, 1'b1, 1'b1, 8'h11);
        chk("restart_idx0", 64'({pix_valid, pix_row, pix_col}), 64'h40);
        drain(64, 1'b0, 200);
        chk("restart_queue_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
